// File: rtl/biu_pkg.sv
// Shared types, widths and address helper for the BIU prefetch/fetch logic.
package biu_pkg;

  localparam int ADDR_W    = 20;
  localparam int DATA_W    = 16;
  localparam int SEG_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FETCH_WAIT   = 2'd1,
    DATA_RD_WAIT = 2'd2,
    DATA_WR      = 2'd3
  } fetch_state_t;

  // Real-mode segment:offset translation; the carry out of bit 19 is dropped.
  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
    return {cs, {SEG_SHIFT{1'b0}}} + {{SEG_SHIFT{1'b0}}, ip};
  endfunction

endpackage

// File: rtl/prefetch_queue.sv
// Byte FIFO for the instruction stream: two-byte push, one-byte pop, clear.
module prefetch_queue #(
  parameter int QUEUE_DEPTH = 6
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               clear,
  input  logic                               push,
  input  logic [15:0]                        push_word,
  input  logic                               pop,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count,
  output logic [7:0]                         head,
  output logic                               valid
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [7:0]    mem_q [QUEUE_DEPTH];
  logic [7:0]    mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_s;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    pop_s   = pop && (count_q != '0);
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q]          = push_word[7:0];
        mem_d[ptr_inc(wr_q)] = push_word[15:8];
        wr_d                 = ptr_inc(ptr_inc(wr_q));
      end else begin
        wr_d = wr_q;
      end
      rd_d    = pop_s ? ptr_inc(rd_q) : rd_q;
      count_d = count_q + (push ? CW'(2) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: 8'h00};
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign valid = (count_q != '0);
  assign head  = valid ? mem_q[rd_q] : 8'h00;

endmodule

// File: rtl/biu_prefetch_fetcher.sv
// BIU memory master: arbitrates EU data accesses over instruction prefetch
// and keeps the byte queue topped up from CS:IP.
module biu_prefetch_fetcher
  import biu_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 6,
  parameter logic [15:0] RESET_CS    = 16'hFFFF,
  parameter logic [15:0] RESET_IP    = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic              flush,
  input  logic [15:0]       flush_cs,
  input  logic [15:0]       flush_ip,
  input  logic              queue_pop,
  output logic [7:0]        queue_data,
  output logic              queue_valid,
  input  logic              eu_req,
  input  logic              eu_write,
  input  logic [ADDR_W-1:0] eu_address,
  input  logic [DATA_W-1:0] eu_wdata,
  output logic              eu_ack,
  output logic [DATA_W-1:0] eu_rdata
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic              phase_q, phase_d;
  logic              discard_q, discard_d;
  logic [15:0]       cs_q, cs_d, ip_q, ip_d, ip_next_s;
  logic              read_enable_q, read_enable_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              write_enable_q, write_enable_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              eu_ack_q, eu_ack_d;
  logic [DATA_W-1:0] eu_rdata_q, eu_rdata_d;
  logic [CW-1:0]     q_count_s;
  logic              q_push_s;
  logic              can_fetch_s;

  // Fetch only when a whole word still fits; a flush always wins the slot.
  assign can_fetch_s = (q_count_s <= CW'(QUEUE_DEPTH - 2)) && !flush;

  prefetch_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .clear     (flush),
    .push      (q_push_s),
    .push_word (read_data),
    .pop       (queue_pop),
    .count     (q_count_s),
    .head      (queue_data),
    .valid     (queue_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Read accesses need two edges after the strobe; phase marks the second.
  always_comb begin
    state_d = state_q;
    phase_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (eu_req) begin
          state_d = eu_write ? DATA_WR : DATA_RD_WAIT;
        end else if (can_fetch_s) begin
          state_d = FETCH_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH_WAIT, DATA_RD_WAIT: begin
        if (phase_q) begin
          state_d = IDLE;
        end else begin
          phase_d = 1'b1;
        end
      end
      DATA_WR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_enable_d   = 1'b0;
    read_address_d  = read_address_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    eu_ack_d        = 1'b0;
    eu_rdata_d      = eu_rdata_q;
    q_push_s        = 1'b0;
    discard_d       = 1'b0;
    ip_next_s       = ip_q;
    case (state_q)
      IDLE: begin
        if (eu_req && eu_write) begin
          write_enable_d  = 1'b1;
          write_address_d = eu_address;
          write_data_d    = eu_wdata;
        end else if (eu_req) begin
          read_enable_d  = 1'b1;
          read_address_d = eu_address;
        end else if (can_fetch_s) begin
          read_enable_d  = 1'b1;
          read_address_d = phys_addr(cs_q, ip_q);
        end else begin
          read_enable_d = 1'b0;
        end
      end
      FETCH_WAIT: begin
        // A flush anywhere in the fetch makes the returning word stale.
        if (!phase_q) begin
          discard_d = flush;
        end else if (!flush && !discard_q) begin
          q_push_s  = 1'b1;
          ip_next_s = ip_q + 16'd2;
        end else begin
          q_push_s = 1'b0;
        end
      end
      DATA_RD_WAIT: begin
        if (phase_q) begin
          eu_ack_d   = 1'b1;
          eu_rdata_d = read_data;
        end else begin
          eu_ack_d = 1'b0;
        end
      end
      DATA_WR: eu_ack_d = 1'b1;
      default: eu_ack_d = 1'b0;
    endcase
    cs_d = flush ? flush_cs : cs_q;
    ip_d = flush ? flush_ip : ip_next_s;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      discard_q       <= 1'b0;
      cs_q            <= RESET_CS;
      ip_q            <= RESET_IP;
      read_enable_q   <= 1'b0;
      read_address_q  <= '0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
      eu_ack_q        <= 1'b0;
      eu_rdata_q      <= '0;
    end else begin
      discard_q       <= discard_d;
      cs_q            <= cs_d;
      ip_q            <= ip_d;
      read_enable_q   <= read_enable_d;
      read_address_q  <= read_address_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      eu_ack_q        <= eu_ack_d;
      eu_rdata_q      <= eu_rdata_d;
    end
  end

  assign read_enable   = read_enable_q;
  assign read_address  = read_address_q;
  assign write_enable  = write_enable_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign eu_ack        = eu_ack_q;
  assign eu_rdata      = eu_rdata_q;

endmodule

// File: tb/tb_biu_prefetch_fetcher.sv
// Directed bench for biu_prefetch_fetcher with a one-cycle-latency memory model.
module tb_biu_prefetch_fetcher;

  logic        clock, reset;
  logic        read_enable, write_enable;
  logic [19:0] read_address, write_address;
  logic [15:0] read_data, write_data;
  logic        flush;
  logic [15:0] flush_cs, flush_ip;
  logic        queue_pop;
  logic [7:0]  queue_data;
  logic        queue_valid;
  logic        eu_req, eu_write;
  logic [19:0] eu_address;
  logic [15:0] eu_wdata, eu_rdata;
  logic        eu_ack;

  int checks = 0;
  int failures = 0;

  biu_prefetch_fetcher #(.QUEUE_DEPTH(6), .RESET_CS(16'hFFFF), .RESET_IP(16'h0000)) dut (
    .clock(clock), .reset(reset),
    .read_enable(read_enable), .read_address(read_address), .read_data(read_data),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .flush(flush), .flush_cs(flush_cs), .flush_ip(flush_ip),
    .queue_pop(queue_pop), .queue_data(queue_data), .queue_valid(queue_valid),
    .eu_req(eu_req), .eu_write(eu_write), .eu_address(eu_address), .eu_wdata(eu_wdata),
    .eu_ack(eu_ack), .eu_rdata(eu_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0]  wr_mem [0:15];
  logic [15:0] wr_vld;

  // Memory contents: reset vector word, bytes written at low addresses, else a pattern.
  function automatic logic [7:0] byte_at(input logic [19:0] a);
    if (a == 20'hFFFF0) return 8'h90;
    else if (a == 20'hFFFF1) return 8'hEA;
    else if (a < 20'd16 && wr_vld[a[3:0]]) return wr_mem[a[3:0]];
    else return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'hA5;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data <= 16'h0000;
      wr_vld    <= 16'h0000;
    end else begin
      if (read_enable) read_data <= {byte_at(read_address + 20'd1), byte_at(read_address)};
      if (write_enable && write_address < 20'd15) begin
        wr_mem[write_address[3:0]]        <= write_data[7:0];
        wr_mem[write_address[3:0] + 4'd1] <= write_data[15:8];
        wr_vld[write_address[3:0]]        <= 1'b1;
        wr_vld[write_address[3:0] + 4'd1] <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (read_enable !== 1'b0) begin failures++; $display("FAIL reset_read_enable got=%0h exp=0", read_enable); end
    checks++; if (read_address !== 20'h0) begin failures++; $display("FAIL reset_read_address got=%0h exp=0", read_address); end
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_write_enable got=%0h exp=0", write_enable); end
    checks++; if (write_address !== 20'h0 || write_data !== 16'h0) begin failures++; $display("FAIL reset_write_bus got=%0h/%0h exp=0/0", write_address, write_data); end
    checks++; if (eu_ack !== 1'b0 || eu_rdata !== 16'h0) begin failures++; $display("FAIL reset_eu got=%0h/%0h exp=0/0", eu_ack, eu_rdata); end
    checks++; if (queue_valid !== 1'b0 || queue_data !== 8'h00) begin failures++; $display("FAIL reset_queue got=%0h/%0h exp=0/0", queue_valid, queue_data); end
    reset = 1'b1;
  endtask

  task automatic test_initial_fill();
    logic [19:0] addrs[$];
    logic [19:0] exp_a [3];
    exp_a = '{20'hFFFF0, 20'hFFFF2, 20'hFFFF4};
    for (int i = 0; i < 20; i++) begin
      step();
      if (read_enable) addrs.push_back(read_address);
      if (i == 0) begin
        checks++; if (read_enable !== 1'b1 || read_address !== 20'hFFFF0) begin failures++; $display("FAIL fill_first_fetch got=%0h@%0h exp=1@FFFF0", read_enable, read_address); end
      end
      if (i == 1) begin
        checks++; if (read_enable !== 1'b0) begin failures++; $display("FAIL fill_strobe_drop got=%0h exp=0", read_enable); end
      end
      if (i == 2) begin
        checks++; if (queue_valid !== 1'b1 || queue_data !== 8'h90) begin failures++; $display("FAIL fill_first_byte got=%0h/%0h exp=1/90", queue_valid, queue_data); end
      end
    end
    checks++;
    if (addrs.size() != 3) begin
      failures++; $display("FAIL fill_fetch_count got=%0d exp=3", addrs.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (addrs[k] !== exp_a[k]) begin failures++; $display("FAIL fill_fetch_addr[%0d] got=%0h exp=%0h", k, addrs[k], exp_a[k]); end
      end
    end
  endtask

  task automatic test_eu_write();
    eu_write = 1'b1; eu_address = 20'h00001; eu_wdata = 16'h0001; eu_req = 1'b1;
    step();
    checks++; if (write_enable !== 1'b1 || write_address !== 20'h00001 || write_data !== 16'h0001) begin failures++; $display("FAIL wr_issue got=%0h %0h %0h exp=1 00001 0001", write_enable, write_address, write_data); end
    checks++; if (eu_ack !== 1'b0 || read_enable !== 1'b0) begin failures++; $display("FAIL wr_issue_side got=ack%0h re%0h exp=0 0", eu_ack, read_enable); end
    step();
    checks++; if (write_enable !== 1'b0 || eu_ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=we%0h ack%0h exp=0 1", write_enable, eu_ack); end
    eu_req = 1'b0;
    step();
    checks++; if (eu_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_pulse got=%0h exp=0", eu_ack); end
    eu_write = 1'b0; eu_req = 1'b1;
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h00001) begin failures++; $display("FAIL rb_issue got=%0h@%0h exp=1@00001", read_enable, read_address); end
    step();
    checks++; if (eu_ack !== 1'b0) begin failures++; $display("FAIL rb_early_ack got=%0h exp=0", eu_ack); end
    step();
    checks++; if (eu_ack !== 1'b1 || eu_rdata !== 16'h0001) begin failures++; $display("FAIL rb_data got=%0h/%0h exp=1/0001", eu_ack, eu_rdata); end
    eu_req = 1'b0;
    step();
    checks++; if (eu_ack !== 1'b0 || read_enable !== 1'b0) begin failures++; $display("FAIL rb_idle_full got=ack%0h re%0h exp=0 0", eu_ack, read_enable); end
  endtask

  task automatic test_eu_read_during_fill();
    logic [15:0] exp_w;
    exp_w = {byte_at(20'h00011), byte_at(20'h00010)};
    flush = 1'b1; flush_cs = 16'h0200; flush_ip = 16'h0000;
    step();
    flush = 1'b0;
    checks++; if (read_enable !== 1'b0 || queue_valid !== 1'b0) begin failures++; $display("FAIL rd_flush_idle got=re%0h v%0h exp=0 0", read_enable, queue_valid); end
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h02000) begin failures++; $display("FAIL rd_fetch_issue got=%0h@%0h exp=1@02000", read_enable, read_address); end
    eu_write = 1'b0; eu_address = 20'h00010; eu_req = 1'b1;
    step();
    step();
    checks++; if (read_enable !== 1'b0 || queue_valid !== 1'b1) begin failures++; $display("FAIL rd_fetch_not_aborted got=re%0h v%0h exp=0 1", read_enable, queue_valid); end
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h00010) begin failures++; $display("FAIL rd_eu_issue got=%0h@%0h exp=1@00010", read_enable, read_address); end
    step();
    checks++; if (eu_ack !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%0h exp=0", eu_ack); end
    step();
    checks++; if (eu_ack !== 1'b1 || eu_rdata !== exp_w) begin failures++; $display("FAIL rd_eu_data got=%0h/%0h exp=1/%0h", eu_ack, eu_rdata, exp_w); end
    eu_req = 1'b0;
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h02002) begin failures++; $display("FAIL rd_prefetch_resume got=%0h@%0h exp=1@02002", read_enable, read_address); end
  endtask

  task automatic test_flush_fetch_wait();
    repeat (10) step();
    checks++; if (queue_data !== byte_at(20'h02000)) begin failures++; $display("FAIL fl_head got=%0h exp=%0h", queue_data, byte_at(20'h02000)); end
    queue_pop = 1'b1;
    step();
    checks++; if (queue_data !== byte_at(20'h02001)) begin failures++; $display("FAIL fl_pop_head got=%0h exp=%0h", queue_data, byte_at(20'h02001)); end
    step();
    queue_pop = 1'b0;
    checks++; if (read_enable !== 1'b0) begin failures++; $display("FAIL fl_no_fetch_at5 got=%0h exp=0", read_enable); end
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h02006) begin failures++; $display("FAIL fl_fetch_issue got=%0h@%0h exp=1@02006", read_enable, read_address); end
    flush = 1'b1; flush_cs = 16'h1000; flush_ip = 16'h0020;
    step();
    flush = 1'b0;
    checks++; if (queue_valid !== 1'b0) begin failures++; $display("FAIL fl_cleared got=%0h exp=0", queue_valid); end
    step();
    checks++; if (queue_valid !== 1'b0 || read_enable !== 1'b0) begin failures++; $display("FAIL fl_stale_dropped got=v%0h re%0h exp=0 0", queue_valid, read_enable); end
    step();
    checks++; if (read_enable !== 1'b1 || read_address !== 20'h10020) begin failures++; $display("FAIL fl_new_fetch got=%0h@%0h exp=1@10020", read_enable, read_address); end
    step();
    step();
    checks++; if (queue_valid !== 1'b1 || queue_data !== byte_at(20'h10020)) begin failures++; $display("FAIL fl_new_byte got=%0h/%0h exp=1/%0h", queue_valid, queue_data, byte_at(20'h10020)); end
  endtask

  task automatic test_ip_wrap_stream();
    logic [19:0] addrs[$];
    logic [7:0]  bytes[$];
    logic [19:0] ea;
    flush = 1'b1; flush_cs = 16'h0000; flush_ip = 16'hFFFE; queue_pop = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (queue_valid !== 1'b0) begin failures++; $display("FAIL wrap_flush_beats_pop got=%0h exp=0", queue_valid); end
    for (int i = 0; i < 30; i++) begin
      step();
      if (read_enable) addrs.push_back(read_address);
      if (queue_valid) bytes.push_back(queue_data);
    end
    queue_pop = 1'b0;
    checks++;
    if (addrs.size() < 2) begin
      failures++; $display("FAIL wrap_fetch_count got=%0d exp>=2", addrs.size());
    end else begin
      checks++; if (addrs[0] !== 20'h0FFFE) begin failures++; $display("FAIL wrap_addr0 got=%0h exp=0FFFE", addrs[0]); end
      checks++; if (addrs[1] !== 20'h00000) begin failures++; $display("FAIL wrap_addr1 got=%0h exp=00000", addrs[1]); end
    end
    checks++;
    if (bytes.size() < 8) begin
      failures++; $display("FAIL wrap_byte_count got=%0d exp>=8", bytes.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        ea = (k < 2) ? 20'h0FFFE + 20'(k) : 20'(k - 2);
        checks++; if (bytes[k] !== byte_at(ea)) begin failures++; $display("FAIL wrap_stream[%0d] got=%0h exp=%0h", k, bytes[k], byte_at(ea)); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; flush_cs = 16'h0; flush_ip = 16'h0; queue_pop = 1'b0;
    eu_req = 1'b0; eu_write = 1'b0; eu_address = 20'h0; eu_wdata = 16'h0;
    #2 reset = 1'b0;
    test_reset();
    test_initial_fill();
    test_eu_write();
    test_eu_read_during_fill();
    test_flush_fetch_wait();
    test_ip_wrap_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
